sckgen_mode: RTL and testbench
==============================

// Module: sckgen_mode
// PURPOSE
//  Parametrised successor to sckgen: SPI serial-clock generator for the LCD/peripheral SPI masters.
//  Generates framed SCK bursts of N bits with programmable divider and all four SPI modes
//  (CPOL/CPHA), plus per-edge strobes and bit-level sample/shift strobes for the shift register.
//  Sits between the SPI controller FSM (start/done handshake) and the SPI shift/IO logic.
// PARAMETERS
//  DIV_W   8   width of i_baudrate; half-period = i_baudrate+1 sysclk cycles (1..2^DIV_W)
//  CNT_W   5   width of i_nbits; frame length 1..2^CNT_W-1 bits
// PORTS
//  i_sysclk    in   1      system clock; the only clock
//  i_sysrst    in   1      synchronous, active-high reset
//  i_en        in   1      block enable; low aborts any frame
//  i_baudrate  in   DIV_W  divider; latched at frame start
//  i_cpol      in   1      SCK idle level
//  i_cpha      in   1      0: sample leading/shift trailing; 1: shift leading/sample trailing
//  i_nbits     in   CNT_W  bits per frame; latched at start; 0 = start ignored
//  i_start     in   1      1-cycle frame request; honoured only in IDLE with i_en=1
//  o_busy      out  1      high from the cycle after accepted start until o_done / abort
//  o_sck       out  1      registered SCK
//  o_sck_rise  out  1      1-cycle pulse, high in the first cycle o_sck is 1 after being 0
//  o_sck_fall  out  1      1-cycle pulse, high in the first cycle o_sck is 0 after being 1
//  o_sample    out  1      1-cycle pulse coincident with the sampling edge strobe
//  o_shift     out  1      1-cycle pulse coincident with the shifting edge strobe
//  o_done      out  1      1-cycle pulse at frame end
// BEHAVIOUR
//  Reset: state=IDLE; o_sck=0, all strobes/o_busy/o_done=0; counters cleared.
//  IDLE: o_sck <= i_cpol each cycle (1-cycle lag when CPOL changes); strobes 0.
//  IDLE->RUN: i_start & i_en & i_nbits!=0; latch baud, nbits, cpol, cpha; half-cnt=0, edge-cnt=0.
//  RUN: half-cnt counts 0..baud; on terminal count toggle o_sck, pulse rise/fall, edge-cnt++.
//   First edge occurs baud+1 cycles after the accept cycle. Total edges = 2*nbits.
//   Leading edge = idle->active, trailing = active->idle.
//   CPHA=0: o_sample on leading edges; o_shift on trailing edges except the last (suppressed).
//   CPHA=1: o_shift on all leading edges; o_sample on all trailing edges.
//  RUN->GUARD after edge 2*nbits: SCK held at CPOL for one further half-period (baud+1 cycles).
//  GUARD->IDLE: o_done pulses in the GUARD terminal cycle; o_busy drops the same cycle.
//  i_start while busy: ignored (no queueing). i_baudrate/i_nbits/mode changes mid-frame: ignored.
//  i_en low in any non-IDLE state: next cycle IDLE, o_sck=latched CPOL, no edge strobes, no o_done.
//  i_sysrst mid-frame: immediate reset values next cycle regardless of state.
//  baud=0: SCK period 2 cycles, strobes every cycle in RUN; max baud gives half-period 2^DIV_W.
//  Edge counter CNT_W+1 bits wide; no wrap possible for nbits<=2^CNT_W-1.
// STRUCTURE
//  Package spi_pkg: state encoding (IDLE, RUN, GUARD), SPI mode constants, default DIV_W/CNT_W.
//  One sub-module natural: sckgen_div (DIV_W half-period counter with load/terminal pulse);
//  FSM, edge counter, mode decode in top level.
// TESTING (50 MHz, 20 ns clock)
//  Reset 5 cycles, cpol=1 -> o_sck=0 during reset, 1 one cycle after release; all strobes 0.
//  Mode0, baud=0, nbits=8, start -> 16 edges, period 40 ns, 8 sample on rises, 7 shift, 1 done.
//  Mode3, baud=3, nbits=4 -> first fall 4 cycles after accept, 4 shift(fall), 4 sample(rise), done.
//  Start during frame and nbits=0 start -> ignored: edge count and done count unchanged.
//  i_en low after 5 edges of 8-bit frame -> SCK back to CPOL next cycle, no done, busy low.
//  Sweep baud 0..255 with nbits=31 -> measured half-period = baud+1 cycles for every frame.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI serial-clock generator: state encoding,
// SPI mode constants, default widths and the per-edge strobe decode.
package spi_pkg;

    localparam int DIV_W_DEF = 8;
    localparam int CNT_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_GUARD = 2'd2
    } sck_state_t;

    // Mode number encodes {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // Returns {sample, shift} for one SCK edge.
    function automatic logic [1:0] edge_strobes(input logic cpha,
                                                input logic leading,
                                                input logic last);
        logic [1:0] strb;
        if (!cpha)
            strb = {leading, ~leading & ~last};
        else
            strb = {~leading, leading};
        return strb;
    endfunction

endpackage

// File: rtl/sckgen_div.sv
// Half-period counter: counts 0..limit while run is high and flags the
// terminal count combinationally so the caller can act on the same edge.
module sckgen_div
    import spi_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] limit,
    output logic             tc
);

    logic [DIV_W-1:0] cnt;

    assign tc = run && (cnt == limit);

    always_ff @(posedge clk) begin
        if (rst || load)
            cnt <= '0;
        else if (run)
            cnt <= tc ? '0 : cnt + DIV_W'(1);
    end

endmodule

// File: rtl/sckgen_mode.sv
// SPI serial-clock generator: framed SCK bursts with programmable divider,
// all four CPOL/CPHA modes, edge strobes and shift-register sample/shift strobes.
module sckgen_mode
    import spi_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_sysclk,
    input  logic             i_sysrst,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_baudrate,
    input  logic             i_cpol,
    input  logic             i_cpha,
    input  logic [CNT_W-1:0] i_nbits,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_sck,
    output logic             o_sck_rise,
    output logic             o_sck_fall,
    output logic             o_sample,
    output logic             o_shift,
    output logic             o_done
);

    sck_state_t       state;
    logic [DIV_W-1:0] baud_q;
    logic [CNT_W-1:0] nbits_q;
    logic             cpol_q;
    logic             cpha_q;
    logic [CNT_W:0]   edge_cnt;
    logic             tc;
    logic             accept;
    logic             leading;
    logic             last_edge;
    logic [1:0]       strb;

    assign accept    = i_start && i_en && (i_nbits != '0);
    // Even edge indices move SCK away from CPOL (leading), odd ones return it
    assign leading   = ~edge_cnt[0];
    assign last_edge = (edge_cnt == ({nbits_q, 1'b0} - (CNT_W+1)'(1)));
    assign strb      = edge_strobes(cpha_q, leading, last_edge);

    sckgen_div #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk   (i_sysclk),
        .rst   (i_sysrst),
        .load  (state == ST_IDLE),
        .run   ((state != ST_IDLE) && i_en),
        .limit (baud_q),
        .tc    (tc)
    );

    // Frame parameters are data: captured at accept, never reset
    always_ff @(posedge i_sysclk) begin
        if (state == ST_IDLE && accept) begin
            baud_q  <= i_baudrate;
            nbits_q <= i_nbits;
            cpol_q  <= i_cpol;
            cpha_q  <= i_cpha;
        end
    end

    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            state      <= ST_IDLE;
            o_sck      <= 1'b0;
            o_busy     <= 1'b0;
            o_sck_rise <= 1'b0;
            o_sck_fall <= 1'b0;
            o_sample   <= 1'b0;
            o_shift    <= 1'b0;
            o_done     <= 1'b0;
            edge_cnt   <= '0;
        end else begin
            o_sck_rise <= 1'b0;
            o_sck_fall <= 1'b0;
            o_sample   <= 1'b0;
            o_shift    <= 1'b0;
            o_done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    o_sck  <= i_cpol;
                    o_busy <= 1'b0;
                    if (accept) begin
                        state    <= ST_RUN;
                        o_busy   <= 1'b1;
                        edge_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (!i_en) begin
                        state  <= ST_IDLE;
                        o_sck  <= cpol_q;
                        o_busy <= 1'b0;
                    end else if (tc) begin
                        o_sck      <= ~o_sck;
                        o_sck_rise <= ~o_sck;
                        o_sck_fall <= o_sck;
                        o_sample   <= strb[1];
                        o_shift    <= strb[0];
                        edge_cnt   <= edge_cnt + (CNT_W+1)'(1);
                        if (last_edge)
                            state <= ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    if (!i_en) begin
                        state  <= ST_IDLE;
                        o_sck  <= cpol_q;
                        o_busy <= 1'b0;
                    end else if (tc) begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sckgen_mode.sv
// Scoreboard bench for sckgen_mode: expected edge/done events are queued by the
// stimulus and popped by a monitor each time the DUT shows a strobe.
`timescale 1ns/1ps
module tb_sckgen_mode;

    logic       clk = 1'b0;
    logic       rst, en, cpol, cpha, start;
    logic [7:0] baud;
    logic [4:0] nbits;
    logic       busy, sck, sck_rise, sck_fall, sample, shift, done;

    typedef struct packed {
        logic        done;
        logic        rise;
        logic        fall;
        logic        sample;
        logic        shift;
        logic        sck;
        logic        busy;
        logic [15:0] gap;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  gap_cnt = 0;
    int  n_edges = 0;
    int  n_done = 0;
    int  n_busy_rise = 0;
    logic busy_d = 1'b0;

    always #10 clk = ~clk;

    sckgen_mode dut (
        .i_sysclk   (clk),
        .i_sysrst   (rst),
        .i_en       (en),
        .i_baudrate (baud),
        .i_cpol     (cpol),
        .i_cpha     (cpha),
        .i_nbits    (nbits),
        .i_start    (start),
        .o_busy     (busy),
        .o_sck      (sck),
        .o_sck_rise (sck_rise),
        .o_sck_fall (sck_fall),
        .o_sample   (sample),
        .o_shift    (shift),
        .o_done     (done)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Expected events for one frame, derived from mode and edge index alone.
    task automatic push_frame(input logic p_cpol, input logic p_cpha, input int p_baud,
                              input int p_nbits, input int max_edges, input bit with_done);
        ev_t e;
        bit  lead;
        for (int k = 0; k < 2*p_nbits && k < max_edges; k++) begin
            lead     = (k % 2 == 0);
            e.sck    = lead ? ~p_cpol : p_cpol;
            e.rise   = e.sck;
            e.fall   = ~e.sck;
            e.done   = 1'b0;
            e.busy   = 1'b1;
            if (!p_cpha) begin
                e.sample = lead;
                e.shift  = !lead && (k != 2*p_nbits - 1);
            end else begin
                e.shift  = lead;
                e.sample = !lead;
            end
            e.gap = 16'(p_baud + 1);
            exp_q.push_back(e);
        end
        if (with_done) begin
            e = '0;
            e.done = 1'b1;
            e.sck  = p_cpol;
            e.gap  = 16'(p_baud + 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        total++;
        if (i >= budget) begin
            bad++;
            $display("FAIL %s: timeout after %0d cycles, pending %0d events", nm, i, exp_q.size());
        end
        #1;
    endtask

    // Monitor: gap is counted from busy rising or from the previous event
    always @(negedge clk) begin
        ev_t act, exp;
        if (rst) begin
            gap_cnt = 0;
            busy_d  = 1'b0;
        end else begin
            gap_cnt++;
            if (busy && !busy_d) begin
                gap_cnt = 0;
                n_busy_rise++;
            end
            busy_d = busy;
            if (sck_rise || sck_fall || done || sample || shift) begin
                act = {done, sck_rise, sck_fall, sample, shift, sck, busy, 16'(gap_cnt)};
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got %h want none", act);
                end else begin
                    exp = exp_q.pop_front();
                    check("event", 64'(act), 64'(exp));
                end
                if (sck_rise || sck_fall) n_edges++;
                if (done) n_done++;
                gap_cnt = 0;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bauds[10] = '{0, 1, 2, 3, 7, 15, 31, 63, 127, 255};
        int target;
        int i;
        rst = 1'b1; en = 1'b1; cpol = 1'b1; cpha = 1'b0;
        baud = 8'd0; nbits = 5'd0; start = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check("reset_outputs", 64'({sck, busy, sck_rise, sck_fall, sample, shift, done}), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_sck_cpol", 64'(sck), 64'(1));

        // Mode 0, fastest divider, plus an ignored mid-frame start
        cpol = 1'b0; cpha = 1'b0; baud = 8'd0; nbits = 5'd8;
        @(posedge clk); #1;
        check("idle_sck_cpol0", 64'(sck), 64'(0));
        push_frame(1'b0, 1'b0, 0, 8, 99, 1'b1);
        start_pulse();
        repeat (3) @(posedge clk);
        start_pulse();
        wait_idle(200, "mode0_frame");
        check("mode0_edges", 64'(n_edges), 64'(16));
        check("mode0_done", 64'(n_done), 64'(1));
        check("mode0_frames", 64'(n_busy_rise), 64'(1));

        // nbits = 0 start is ignored
        nbits = 5'd0;
        start_pulse();
        repeat (10) @(posedge clk);
        #1;
        check("nbits0_busy", 64'(n_busy_rise), 64'(1));
        check("nbits0_edges", 64'(n_edges), 64'(16));

        // Mode 3, baud 3
        cpol = 1'b1; cpha = 1'b1; baud = 8'd3; nbits = 5'd4;
        @(posedge clk); #1;
        push_frame(1'b1, 1'b1, 3, 4, 99, 1'b1);
        start_pulse();
        wait_idle(200, "mode3_frame");
        check("mode3_edges", 64'(n_edges), 64'(24));
        check("mode3_done", 64'(n_done), 64'(2));

        // Abort after 5 edges
        cpol = 1'b0; cpha = 1'b0; baud = 8'd3; nbits = 5'd8;
        @(posedge clk); #1;
        push_frame(1'b0, 1'b0, 3, 8, 5, 1'b0);
        start_pulse();
        target = n_edges + 5;
        for (i = 0; i < 200; i++) begin
            @(posedge clk);
            if (n_edges >= target) break;
        end
        check("abort_reach5", 64'(n_edges), 64'(target));
        #1 en = 1'b0;
        @(posedge clk); #1;
        check("abort_sck", 64'(sck), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        en = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("abort_no_done", 64'(n_done), 64'(2));
        check("abort_queue", 64'(exp_q.size()), 64'(0));

        // Divider sweep
        cpol = 1'b0; cpha = 1'b1; nbits = 5'd31;
        foreach (bauds[j]) begin
            baud = 8'(bauds[j]);
            @(posedge clk); #1;
            push_frame(1'b0, 1'b1, bauds[j], 31, 99, 1'b1);
            start_pulse();
            wait_idle((bauds[j] + 1) * 70 + 50, "sweep_frame");
        end
        check("sweep_done", 64'(n_done), 64'(12));
        check("final_queue", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
